// File: rtl/pcie_cpl_tlp_fifo.sv
// Completion-TLP buffer: sop/eop framer in front of a DEPTH-beat FIFO feeding the PCIe core TX path.
// Define PCIE_CPL_FIFO_STORE_FWD_EN to hold each packet until its eop beat has been stored.
module pcie_cpl_tlp_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH/32,
    parameter int HDR_WIDTH  = 128,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_cpl_tlp_data,
    input  logic [STRB_WIDTH-1:0]     s_cpl_tlp_strb,
    input  logic [HDR_WIDTH-1:0]      s_cpl_tlp_hdr,
    input  logic                      s_cpl_tlp_valid,
    input  logic                      s_cpl_tlp_sop,
    input  logic                      s_cpl_tlp_eop,
    output logic                      s_cpl_tlp_ready,
    output logic [DATA_WIDTH-1:0]     m_cpl_tlp_data,
    output logic [STRB_WIDTH-1:0]     m_cpl_tlp_strb,
    output logic [HDR_WIDTH-1:0]      m_cpl_tlp_hdr,
    output logic                      m_cpl_tlp_valid,
    output logic                      m_cpl_tlp_sop,
    output logic                      m_cpl_tlp_eop,
    input  logic                      m_cpl_tlp_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      status_framing_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Handshake: a beat moves only on valid & ready at posedge clk; valid never waits on ready.
    typedef struct packed {
        logic [HDR_WIDTH-1:0]  hdr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  sop;
        logic                  eop;
    } entry_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } framer_state_e;

    framer_state_e framer_state_q;
    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          s_ready_q;
    logic          err_q;
    logic          accept;
    logic          push;
    logic          pop;
    logic          empty;
    logic          bad_frame;
    logic          m_valid_w;

    assign accept    = s_cpl_tlp_valid & s_ready_q;
    assign push      = accept & ((framer_state_q == IN_PKT) | s_cpl_tlp_sop);
    assign bad_frame = accept & ((framer_state_q == IN_PKT) ? s_cpl_tlp_sop : ~s_cpl_tlp_sop);
    // Full-width pointers match exactly when nothing is stored.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign rd_entry  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop       = m_valid_w & m_cpl_tlp_ready;
    assign level_d   = level_q + LW'(push) - LW'(pop);

    always_comb begin
        wr_entry      = '0;
        wr_entry.hdr  = s_cpl_tlp_hdr;
        wr_entry.data = s_cpl_tlp_data;
        wr_entry.strb = s_cpl_tlp_strb;
        wr_entry.sop  = (framer_state_q == IDLE);
        wr_entry.eop  = s_cpl_tlp_eop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            framer_state_q <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            s_ready_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
            level_q   <= level_d;
            s_ready_q <= (level_d < LW'(DEPTH));
            err_q     <= bad_frame;
            case (framer_state_q)
                IDLE:    if (accept & s_cpl_tlp_sop & ~s_cpl_tlp_eop) framer_state_q <= IN_PKT;
                IN_PKT:  if (accept & s_cpl_tlp_eop) framer_state_q <= IDLE;
                default: framer_state_q <= IDLE;
            endcase
        end
    end

`ifdef PCIE_CPL_FIFO_STORE_FWD_EN
    logic [LW-1:0] pkt_count_q;
    logic [LW-1:0] pkt_count_d;
    logic          release_q;

    assign pkt_count_d = pkt_count_q + LW'(push & s_cpl_tlp_eop) - LW'(pop & rd_entry.eop);

    // A packet longer than the FIFO can never complete, so let it stream once the FIFO fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
            release_q   <= 1'b0;
        end else begin
            pkt_count_q <= pkt_count_d;
            if (release_q) begin
                if (pop & rd_entry.eop) release_q <= 1'b0;
            end else if ((level_q == LW'(DEPTH)) && (pkt_count_q == '0)) begin
                release_q <= 1'b1;
            end
        end
    end

    assign m_valid_w = ~empty & ((pkt_count_q != '0) | release_q);
`else
    assign m_valid_w = ~empty;
`endif

    assign s_cpl_tlp_ready    = s_ready_q;
    assign m_cpl_tlp_valid    = m_valid_w;
    assign m_cpl_tlp_data     = rd_entry.data;
    assign m_cpl_tlp_strb     = rd_entry.strb;
    assign m_cpl_tlp_hdr      = rd_entry.hdr;
    assign m_cpl_tlp_sop      = m_valid_w & rd_entry.sop;
    assign m_cpl_tlp_eop      = m_valid_w & rd_entry.eop;
    assign fifo_level         = level_q;
    assign status_framing_err = err_q;

endmodule
